// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 bus demultiplexer: width, channel codes, slot states.
package demux_pkg;

   localparam int unsigned WIDTH = 8;

   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_1to4_8b_if.sv
// Source/destination bundle of the 1-to-4 demultiplexer.
// input_broadcast exists only when DEMUX_BROADCAST_EN is defined.
interface demux_1to4_8b_if #(
   parameter int unsigned WIDTH = demux_pkg::WIDTH
);
   logic [WIDTH-1:0] input_data;
   logic             input_select1;
   logic             input_select2;
   logic             input_valid;
   logic             output_ready;
`ifdef DEMUX_BROADCAST_EN
   logic             input_broadcast;
`endif
   logic [WIDTH-1:0] output_a;
   logic [WIDTH-1:0] output_b;
   logic [WIDTH-1:0] output_c;
   logic [WIDTH-1:0] output_d;
   logic             output_valid_a;
   logic             output_valid_b;
   logic             output_valid_c;
   logic             output_valid_d;
   logic             input_ack_a;
   logic             input_ack_b;
   logic             input_ack_c;
   logic             input_ack_d;

   // Source and consumers together form the master side.
   modport master (
      output input_data, input_select1, input_select2, input_valid,
`ifdef DEMUX_BROADCAST_EN
      output input_broadcast,
`endif
      output input_ack_a, input_ack_b, input_ack_c, input_ack_d,
      input  output_ready,
      input  output_a, output_b, output_c, output_d,
      input  output_valid_a, output_valid_b, output_valid_c, output_valid_d
   );

   modport slave (
      input  input_data, input_select1, input_select2, input_valid,
`ifdef DEMUX_BROADCAST_EN
      input  input_broadcast,
`endif
      input  input_ack_a, input_ack_b, input_ack_c, input_ack_d,
      output output_ready,
      output output_a, output_b, output_c, output_d,
      output output_valid_a, output_valid_b, output_valid_c, output_valid_d
   );

endinterface

// File: rtl/demux_slot_8b.sv
// One-word holding slot with valid/ack handshake; a load while acked passes straight through.
module demux_slot_8b
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ack,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             can_load
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (load) begin
         state_d = FULL;
         data_d  = data_in;
      end else if (ack && state_q == FULL) begin
         // Data is left in place after draining; consumers qualify with valid.
         state_d = EMPTY;
      end
   end

   assign data_out = data_q;
   assign valid    = (state_q == FULL);
   assign can_load = (state_q == EMPTY) || ack;

endmodule

// File: rtl/demux_1to4_8b.sv
// 1-to-4 8-bit bus demultiplexer: routes each source word to one of four handshaked slots.
// Define DEMUX_BROADCAST_EN to add input_broadcast, which loads all four slots at once.
module demux_1to4_8b
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
   input logic            input_clk,
   input logic            input_rst_n,
   demux_1to4_8b_if.slave bus
);

   logic [1:0]       sel;
   logic [3:0]       target;
   logic [3:0]       load;
   logic [3:0]       ack;
   logic [3:0]       valid;
   logic [3:0]       can_load;
   logic [WIDTH-1:0] slot_data [4];
   logic             ready;
   logic             accept;
   logic             bcast;

   assign sel = {bus.input_select2, bus.input_select1};
   assign ack = {bus.input_ack_d, bus.input_ack_c, bus.input_ack_b, bus.input_ack_a};

`ifdef DEMUX_BROADCAST_EN
   assign bcast = bus.input_broadcast;
`else
   assign bcast = 1'b0;
`endif

   always_comb begin
      target = 4'b0000;
      unique case (sel)
         CH_A: target = 4'b0001;
         CH_B: target = 4'b0010;
         CH_C: target = 4'b0100;
         CH_D: target = 4'b1000;
         default: target = 4'b0000;
      endcase
   end

   // Broadcast needs every slot free; otherwise only the selected slot matters.
   always_comb begin
      if (bcast) begin
         ready = input_rst_n && (&can_load);
      end else begin
         ready = input_rst_n && (|(target & can_load));
      end
   end

   assign accept = bus.input_valid && ready;
   assign load   = accept ? (bcast ? 4'b1111 : target) : 4'b0000;

   for (genvar i = 0; i < 4; i++) begin : g_slot
      demux_slot_8b #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk      (input_clk),
         .rst_n    (input_rst_n),
         .load     (load[i]),
         .data_in  (bus.input_data),
         .ack      (ack[i]),
         .data_out (slot_data[i]),
         .valid    (valid[i]),
         .can_load (can_load[i])
      );
   end

   assign bus.output_ready   = ready;
   assign bus.output_a       = slot_data[0];
   assign bus.output_b       = slot_data[1];
   assign bus.output_c       = slot_data[2];
   assign bus.output_d       = slot_data[3];
   assign bus.output_valid_a = valid[0];
   assign bus.output_valid_b = valid[1];
   assign bus.output_valid_c = valid[2];
   assign bus.output_valid_d = valid[3];

endmodule

// File: tb/tb_demux_1to4_8b.sv
// Directed self-checking bench for demux_1to4_8b; broadcast steps run when DEMUX_BROADCAST_EN is set.
module tb_demux_1to4_8b;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   demux_1to4_8b_if #(.WIDTH(8)) bus ();

   demux_1to4_8b #(
      .WIDTH (8)
   ) dut (
      .input_clk   (clk),
      .input_rst_n (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [7:0] data, input logic vld);
      bus.input_select2 = sel[1];
      bus.input_select1 = sel[0];
      bus.input_data    = data;
      bus.input_valid   = vld;
   endtask

   task automatic check_valids(input string tag, input logic [3:0] exp);
      check(tag, {4'b0, bus.output_valid_d, bus.output_valid_c, bus.output_valid_b,
                  bus.output_valid_a}, {4'b0, exp});
   endtask

   task automatic check_outs(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
      check({tag, "_a"}, bus.output_a, a);
      check({tag, "_b"}, bus.output_b, b);
      check({tag, "_c"}, bus.output_c, c);
      check({tag, "_d"}, bus.output_d, d);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.input_ack_a = 1'b0;
      bus.input_ack_b = 1'b0;
      bus.input_ack_c = 1'b0;
      bus.input_ack_d = 1'b0;
`ifdef DEMUX_BROADCAST_EN
      bus.input_broadcast = 1'b0;
`endif
      drive(2'b00, 8'hAA, 1'b1);

      // Reset held for two edges with a word offered.
      step();
      step();
      check_valids("rst_valid", 4'b0000);
      check_outs("rst_out", 8'h00, 8'h00, 8'h00, 8'h00);
      check("rst_ready", {7'b0, bus.output_ready}, 8'h01 ^ 8'h01);

      // Routing to each channel.
      rst_n = 1'b1;
      drive(2'b00, 8'h00, 1'b1);
      #1 check("route_a_ready", {7'b0, bus.output_ready}, 8'h01);
      step();
      drive(2'b01, 8'hF0, 1'b1);
      step();
      drive(2'b10, 8'h0F, 1'b1);
      step();
      check("route_c_out", bus.output_c, 8'h0F);
      drive(2'b11, 8'hFF, 1'b1);
      step();
      drive(2'b00, 8'h00, 1'b0);
      check_outs("route", 8'h00, 8'hF0, 8'h0F, 8'hFF);
      check_valids("route_valid", 4'b1111);

      // Backpressure on full slot b.
      drive(2'b01, 8'h55, 1'b1);
      #1 check("bp_b_ready", {7'b0, bus.output_ready}, 8'h00);
      step();
      check("bp_b_hold", bus.output_b, 8'hF0);
      check_valids("bp_valid", 4'b1111);

      // Drain a, then a accepts while b stays blocked.
      drive(2'b00, 8'h55, 1'b0);
      bus.input_ack_a = 1'b1;
      step();
      bus.input_ack_a = 1'b0;
      check_valids("drain_a", 4'b1110);
      drive(2'b00, 8'h55, 1'b1);
      #1 check("a_ready", {7'b0, bus.output_ready}, 8'h01);
      step();
      drive(2'b00, 8'h00, 1'b0);
      check("a_load", bus.output_a, 8'h55);
      check("b_still", bus.output_b, 8'hF0);

      // Pass-through on c: ack and new word in the same cycle.
      bus.input_ack_c = 1'b1;
      drive(2'b10, 8'hA5, 1'b1);
      #1 check("pt_ready", {7'b0, bus.output_ready}, 8'h01);
      step();
      bus.input_ack_c = 1'b0;
      drive(2'b10, 8'h00, 1'b0);
      check("pt_out", bus.output_c, 8'hA5);
      check_valids("pt_valid", 4'b1111);

      // Drain d, keep last value; a second ack on the empty slot changes nothing.
      bus.input_ack_d = 1'b1;
      step();
      check_valids("drain_d", 4'b0111);
      check("drain_d_keep", bus.output_d, 8'hFF);
      step();
      bus.input_ack_d = 1'b0;
      check_valids("ack_empty_d", 4'b0111);

      // input_valid low loads nothing, even onto an empty target.
      drive(2'b11, 8'h99, 1'b0);
      step();
      check_valids("novalid", 4'b0111);
      check("novalid_d", bus.output_d, 8'hFF);

      // Refill d, then reset mid-operation.
      drive(2'b11, 8'h77, 1'b1);
      step();
      check_valids("refill", 4'b1111);
      rst_n = 1'b0;
      drive(2'b11, 8'h3C, 1'b1);
      #1 check("rst_mid_ready", {7'b0, bus.output_ready}, 8'h00);
      step();
      check_valids("rst_mid_valid", 4'b0000);
      check_outs("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
      rst_n = 1'b1;
      step();
      drive(2'b00, 8'h00, 1'b0);
      check("post_rst_d", bus.output_d, 8'h3C);
      check_valids("post_rst_valid", 4'b1000);

`ifdef DEMUX_BROADCAST_EN
      bus.input_ack_d = 1'b1;
      step();
      bus.input_ack_d = 1'b0;
      bus.input_broadcast = 1'b1;
      drive(2'b10, 8'h81, 1'b1);
      #1 check("bc_ready", {7'b0, bus.output_ready}, 8'h01);
      step();
      check_outs("bc", 8'h81, 8'h81, 8'h81, 8'h81);
      check_valids("bc_valid", 4'b1111);
      // Slot a full and unacked blocks the whole broadcast.
      bus.input_ack_b = 1'b1;
      bus.input_ack_c = 1'b1;
      bus.input_ack_d = 1'b1;
      drive(2'b00, 8'h42, 1'b1);
      #1 check("bc_block_ready", {7'b0, bus.output_ready}, 8'h00);
      bus.input_ack_b = 1'b0;
      bus.input_ack_c = 1'b0;
      bus.input_ack_d = 1'b0;
      step();
      check_outs("bc_block", 8'h81, 8'h81, 8'h81, 8'h81);
      check_valids("bc_block_valid", 4'b1111);
      bus.input_broadcast = 1'b0;
      drive(2'b00, 8'h00, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
